// File: rtl/lfsr_run_ctrl.sv
// rtl/lfsr_run_ctrl.sv - run sequencer: chain reset, clock gate, serial-to-word capture
// Pulses the chain reset, settles, then gates the chain clock while packing chain_q into words.
module lfsr_run_ctrl #(
   parameter int WORD_W     = 32,
   parameter int RST_CYC    = 2,
   parameter int SETTLE_CYC = 2,
   parameter int RUN_WORDS  = 16,
   parameter int CNT_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              chain_q,
   input  logic              word_ready,
   output logic              chain_rst_n,
   output logic              clk_en,
   output logic [WORD_W-1:0] word_data,
   output logic              word_valid,
   output logic [CNT_W-1:0]  word_cnt,
   output logic              busy,
   output logic              done
);

   localparam int BIT_W = $clog2(WORD_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CRST,
      S_SETTLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cyc_cnt;
   logic [CNT_W-1:0]   words_done;
   logic [BIT_W-1:0]   bit_cnt;
   logic [WORD_W-2:0]  shift;
   logic [WORD_W-1:0]  shift_nxt;
   logic               last_bit;
   logic               last_word;
   logic               run_gate;
   logic               sample;
   logic               accept;

   assign last_bit  = (bit_cnt == BIT_W'(WORD_W - 1));
   assign last_word = (words_done == CNT_W'(RUN_WORDS - 1));
   // Freeze the chain with its final bit pending while a completed word is still unaccepted.
   assign run_gate  = !(word_valid && last_bit);
   assign sample    = (state == S_RUN) && run_gate;
   assign accept    = word_valid && word_ready;
   assign shift_nxt = {shift, chain_q};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      chain_rst_n = 1'b1;
      clk_en      = 1'b0;
      busy        = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_CRST;
         end
         S_CRST: begin
            chain_rst_n = 1'b0;
            if (cyc_cnt == CNT_W'(RST_CYC - 1)) state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (cyc_cnt == CNT_W'(SETTLE_CYC - 1)) state_nxt = S_RUN;
         end
         S_RUN: begin
            clk_en = run_gate;
            if (run_gate && last_bit && last_word) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (accept) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_cnt    <= '0;
         words_done <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         word_data  <= '0;
         word_valid <= 1'b0;
         word_cnt   <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            word_valid <= 1'b0;
         end else begin
            if (state_nxt != state) begin
               cyc_cnt <= '0;
            end else if (state == S_CRST || state == S_SETTLE) begin
               cyc_cnt <= cyc_cnt + CNT_W'(1);
            end

            if (state == S_IDLE && start) begin
               word_cnt   <= '0;
               words_done <= '0;
               bit_cnt    <= '0;
               shift      <= '0;
            end else if (accept && word_cnt != {CNT_W{1'b1}}) begin
               word_cnt <= word_cnt + CNT_W'(1);
            end

            if (sample) begin
               shift <= shift_nxt[WORD_W-2:0];
               if (last_bit) begin
                  bit_cnt    <= '0;
                  words_done <= words_done + CNT_W'(1);
                  word_data  <= shift_nxt;
                  word_valid <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  if (accept) word_valid <= 1'b0;
               end
            end else if (accept) begin
               word_valid <= 1'b0;
            end

            if (state == S_DRAIN && accept) done <= 1'b1;
         end
      end
   end

endmodule
